// File: rtl/simon_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : simon_decrypt
// Description : Iterative SIMON32/64 decryption core. On an accepted start
//               edge it expands the 64-bit master key into 32 round keys
//               (one per cycle), then runs the 32 inverse rounds
//               (one per cycle) and pulses done with the plaintext.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_decrypt #(
  parameter int ROUNDS    = 32,
  parameter int KEY_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [16*KEY_WORDS-1:0]   key,
  input  logic [31:0]               cipher_text,
  output logic [31:0]               plain_text,
  output logic                      done,
  output logic                      busy
);

  // Terminal counts: last key-expansion index and first decryption key index.
  localparam logic [4:0] KEYGEN_LAST = 5'(ROUNDS - KEY_WORDS - 1);
  localparam logic [4:0] KEY_LAST    = 5'(ROUNDS - 1);

  // z0 sequence, leftmost character is z0[0].
  localparam logic [0:61] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEYGEN  = 2'd1,
    DECRYPT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        start_q;
  logic        armed;     // set once start has been seen low after reset
  logic [4:0]  cnt;       // round counter in KEYGEN, key index in DECRYPT
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] rk [0:31]; // round-key store, no reset needed

  logic        accept;
  logic [15:0] kg_k0;
  logic [15:0] kg_k1;
  logic [15:0] kg_k3;
  logic [15:0] kg_tmp;
  logic [15:0] kg_tmp2;
  logic [15:0] kg_new;
  logic [15:0] f_y;
  logic [15:0] y_new;

  // A start held high through reset release must not launch an operation,
  // so an edge only counts once start has been observed low after reset.
  assign accept = (state == IDLE) && start && !start_q && armed;

  assign busy = (state == KEYGEN) || (state == DECRYPT);
  assign done = (state == DONE);

  // Key expansion for round-key index cnt+4.
  assign kg_k0   = rk[cnt];
  assign kg_k1   = rk[cnt + 5'd1];
  assign kg_k3   = rk[cnt + 5'd3];
  assign kg_tmp  = {kg_k3[2:0], kg_k3[15:3]} ^ kg_k1;
  assign kg_tmp2 = kg_tmp ^ {kg_tmp[0], kg_tmp[15:1]};
  assign kg_new  = ~kg_k0 ^ kg_tmp2 ^ {15'd0, Z0[cnt]} ^ 16'h0003;

  // Inverse round: f(y) = (ROL1 & ROL8) ^ ROL2.
  assign f_y   = ({y[14:0], y[15]} & {y[7:0], y[15:8]}) ^ {y[13:0], y[15:14]};
  assign y_new = x ^ f_y ^ rk[cnt];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode from accept and terminal counter values.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = KEYGEN;
      KEYGEN:  if (cnt == KEYGEN_LAST) state_next = DECRYPT;
      DECRYPT: if (cnt == 5'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Start edge detection, counter and cipher state datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q    <= 1'b0;
      armed      <= 1'b0;
      cnt        <= 5'd0;
      x          <= 16'h0;
      y          <= 16'h0;
      plain_text <= 32'h0;
    end else begin
      start_q <= start;
      if (!start) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            x   <= cipher_text[31:16];
            y   <= cipher_text[15:0];
            cnt <= 5'd0;
          end
        end
        KEYGEN: begin
          if (cnt == KEYGEN_LAST) cnt <= KEY_LAST;
          else                    cnt <= cnt + 5'd1;
        end
        DECRYPT: begin
          x <= y;
          y <= y_new;
          if (cnt == 5'd0) plain_text <= {y, y_new};
          else             cnt <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Round-key store: master key on accept, one expanded key per KEYGEN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      rk[0] <= key[15:0];
      rk[1] <= key[31:16];
      rk[2] <= key[47:32];
      rk[3] <= key[63:48];
    end else if (state == KEYGEN) begin
      rk[cnt + 5'd4] <= kg_new;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simon_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : tb_simon_decrypt
// Description : Self-checking bench for simon_decrypt. A behavioural SIMON32/64
//               encryptor produces ciphertexts; the DUT must recover the
//               original plaintext with the expected timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_decrypt;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] key;
  logic [31:0] cipher_text;
  logic [31:0] plain_text;
  logic        done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] KAT_KEY = 64'h1918111009080100;
  localparam logic [31:0] KAT_CT  = 32'hc69be9bb;
  localparam logic [31:0] KAT_PT  = 32'h65656877;

  simon_decrypt dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .key         (key),
    .cipher_text (cipher_text),
    .plain_text  (plain_text),
    .done        (done),
    .busy        (busy)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rol(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  // Reference SIMON32/64 encryption from the published algorithm.
  function automatic logic [31:0] simon_encrypt(input logic [63:0] k_in,
                                                input logic [31:0] pt);
    logic [15:0] k [0:31];
    logic [0:61] z;
    logic [15:0] x, y, t;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = k_in[16*i +: 16];
    for (int i = 0; i < 28; i++) begin
      t = ror(k[i+3], 3) ^ k[i+1];
      t = t ^ ror(t, 1);
      k[i+4] = ~k[i] ^ t ^ {15'd0, z[i]} ^ 16'h0003;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int r = 0; r < 32; r++) begin
      t = x;
      x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ k[r];
      y = t;
    end
    return {x, y};
  endfunction

  // One full operation: accept edge, wait for done, check timing and result.
  // hold_pt is the value plain_text must keep until completion.
  task automatic run_op(input logic [63:0] k, input logic [31:0] ct,
                        input logic [31:0] exp_pt, input logic [31:0] hold_pt,
                        input bit pulse_mode, input string tag);
    int n;
    int busy_cnt;
    bit hold_ok;
    bit seen;
    key         = k;
    cipher_text = ct;
    start       = 1'b1;
    @(posedge clk); #1;                       // accept edge 0
    start       = 1'b0;
    key         = {$urandom, $urandom};       // don't-care after accept
    cipher_text = $urandom;
    check_value({tag, " busy_after_accept"}, busy, 1);
    busy_cnt = busy ? 1 : 0;
    hold_ok  = 1'b1;
    seen     = 1'b0;
    n        = 0;
    while (n < 200 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (pulse_mode) start = (n == 5 || n == 30 || n == 60);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (plain_text !== hold_pt) hold_ok = 1'b0;
      end
    end
    check_value({tag, " done_seen"}, seen, 1);
    check_value({tag, " done_latency"}, n, 60);
    check_value({tag, " busy_cycles"}, busy_cnt, 60);
    check_value({tag, " busy_in_done"}, busy, 0);
    check_value({tag, " plain_text"}, plain_text, exp_pt);
    check_value({tag, " plain_text_hold"}, hold_ok, 1);
    @(posedge clk); #1;                       // DONE -> IDLE
    start = 1'b0;
    check_value({tag, " done_one_cycle"}, done, 0);
    check_value({tag, " plain_text_kept"}, plain_text, exp_pt);
  endtask

  initial begin
    logic [63:0] rk;
    logic [31:0] rpt;
    logic [31:0] prev;
    bit          quiet;

    reset       = 1'b1;
    start       = 1'b0;
    key         = 64'h0;
    cipher_text = 32'h0;
    #1;
    check_value("reset plain_text", plain_text, 0);
    check_value("reset done", done, 0);
    check_value("reset busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Known-answer run.
    run_op(KAT_KEY, KAT_CT, KAT_PT, 32'h0, 1'b0, "kat");

    // Start edges during busy and DONE must be ignored.
    run_op(KAT_KEY, KAT_CT, KAT_PT, KAT_PT, 1'b1, "kat_pulse");
    quiet = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy || done) quiet = 1'b0;
    end
    check_value("pulse no_restart", quiet, 1);

    // Asynchronous reset in the middle of an operation.
    key         = KAT_KEY;
    cipher_text = KAT_CT;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_value("midreset plain_text", plain_text, 0);
    check_value("midreset done", done, 0);
    check_value("midreset busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    quiet = 1'b1;
    repeat (70) begin
      @(posedge clk); #1;
      if (busy || done) quiet = 1'b0;
    end
    check_value("midreset no_done", quiet, 1);
    run_op(KAT_KEY, KAT_CT, KAT_PT, 32'h0, 1'b0, "kat_after_reset");

    // Start held high through reset release.
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    quiet = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy || done) quiet = 1'b0;
    end
    check_value("start_held no_op", quiet, 1);
    start = 1'b0;
    @(posedge clk); #1;
    run_op(KAT_KEY, KAT_CT, KAT_PT, 32'h0, 1'b0, "kat_after_held");

    // Random back-to-back operations against the reference encryptor.
    prev = KAT_PT;
    for (int i = 0; i < 200; i++) begin
      rk  = {$urandom, $urandom};
      rpt = $urandom;
      run_op(rk, simon_encrypt(rk, rpt), rpt, prev, 1'b0, "rand");
      prev = rpt;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/simon_decrypt.md
SIMON_DECRYPT -- requirements
Module: simon_decrypt

Interface
REQ-001 The block SHALL have these parameters: ROUNDS, 32, SIMON32/64 round count (fixed value, not for override); KEY_WORDS, 4, 16-bit key words.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request; a 0->1 transition, detected via one registered copy of start, requests an operation.
REQ-005 The block SHALL have port key, input, 64, master key with k0=key[15:0], k1=key[31:16], k2=key[47:32], k3=key[63:48].
REQ-006 The block SHALL have port cipher_text, input, 32, ciphertext with x=[31:16] and y=[15:0].
REQ-007 The block SHALL have port plain_text, output, 32, registered result with the same x/y packing.
REQ-008 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 The block SHALL have port busy, output, 1, high while an operation is in progress.

Function
REQ-010 The block SHALL use FSM states IDLE, KEYGEN, DECRYPT, DONE, with IDLE as the reset state.
REQ-011 The block SHALL accept a request only in IDLE when start=1 and the registered start=0 (rising edge); on that edge it SHALL latch cipher_text into x/y, write k0..k3 into a 32x16 round-key store, clear the round counter, and enter KEYGEN.
REQ-012 The block SHALL ignore rising edges of start in KEYGEN, DECRYPT and DONE; an edge missed this way SHALL NOT be queued.
REQ-013 The block SHALL hold key and cipher_text inputs as don't-care after the accept edge.
REQ-014 KEYGEN SHALL run exactly 28 cycles, writing k(i+4) for i=0..27 per edge: tmp = ROR3(k(i+3)) ^ k(i+1); tmp = tmp ^ ROR1(tmp); k(i+4) = ~k(i) ^ tmp ^ z0[i] ^ 16'h0003.
REQ-015 The z0 sequence, first bit = z0[0], SHALL be 11111010001001010110000111001101111101000100101011000011100110; only bits 0..27 are used.
REQ-016 All arithmetic SHALL be 16-bit, with rotations by wrap-around and no carries.
REQ-017 After the 28th KEYGEN edge, the block SHALL enter DECRYPT with the key index set to 31.
REQ-018 DECRYPT SHALL run exactly 32 cycles, applying keys k31 down to k0, one per edge: x' = y; y' = x ^ f(y) ^ k; f(v) = (ROL1(v) & ROL8(v)) ^ ROL2(v).
REQ-019 On the DECRYPT edge that uses k0, the block SHALL load plain_text with {x',y'}, set done=1, and enter DONE.
REQ-020 DONE SHALL last one cycle, then return to IDLE with done=0.
REQ-021 plain_text SHALL hold its value until the next completion.
REQ-022 Latency SHALL be as follows: with the accept on edge 0, done is high for exactly the cycle after edge 60, and plain_text is valid from edge 60 on.
REQ-023 busy SHALL be 1 from the accept edge through edge 60 (KEYGEN and DECRYPT) and 0 in IDLE and DONE.
REQ-024 A rising edge of start seen in the DONE cycle SHALL be ignored; the earliest next accept is the edge after DONE->IDLE, using a fresh 0->1 transition.
REQ-025 The round and key counters SHALL be 5 bits and SHALL NOT wrap during an operation; state exits are decoded from terminal counts 27 (KEYGEN) and 0 (DECRYPT).

Reset
REQ-026 Asserting reset at any time SHALL immediately set state=IDLE, plain_text=32'h0, done=0, busy=0, the registered start copy=0, the counters=0 and x/y=0.
REQ-027 The round-key store SHALL need no reset; its contents are don't-care until rewritten.
REQ-028 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-029 After release, the block SHALL need a new start 0->1 transition; a start held high through reset release SHALL NOT trigger an operation.

Verification
REQ-030 Known-answer test: key=64'h1918111009080100, cipher_text=32'hc69be9bb, start pulse -> done exactly 60 cycles after accept, plain_text=32'h65656877, busy high 60 cycles.
REQ-031 Random test: 200 random key/plaintext pairs encrypted by the software SIMON32/64 model, ciphertext applied -> plain_text equals the original plaintext, done once per request.
REQ-032 Busy blocking: during the known-answer run, start toggled 0->1 at cycles 5, 30 and 60 -> no restart, a single done, correct result.
REQ-033 Reset mid-run: reset asserted asynchronously at cycle 40 of an operation -> outputs 0 immediately, no done; a following known-answer run passes.
REQ-034 Back-to-back: a second request with a new key/ciphertext on the first allowed edge after DONE -> both results correct, and plain_text holds the first result until the second done.
REQ-035 Start held high: start held high from reset release -> no operation until start drops and rises again.
